// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - Shared FSM states, DMEM width codes and address defaults for the DMEM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Bit_S width codes as seen by the DMEM
    localparam logic [1:0] BITS_WORD = 2'b00;
    localparam logic [1:0] BITS_HALF = 2'b01;
    localparam logic [1:0] BITS_BYTE = 2'b10;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - Two-way combinational grant selection; round-robin tie-break when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick (
    input  logic i_req0,
    input  logic i_req1,
`ifdef DMEM_ARB_RR_EN
    input  logic i_ptr,
`endif
    output logic o_valid,
    output logic o_win
);

    always_comb begin
        o_valid = i_req0 | i_req1;
`ifdef DMEM_ARB_RR_EN
        o_win = (i_req0 & i_req1) ? i_ptr : i_req1;
`else
        o_win = ~i_req0 & i_req1;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - Two-requester DMEM arbiter with fixed 3-cycle IDLE/ACCESS/RESP transaction.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEFAULT,
    parameter int          AW        = 11
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic [1:0]    r0_bits,
    output logic          r0_ack,
    output logic          r0_err,
    output logic [31:0]   r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [31:0]   r1_wdata,
    input  logic [1:0]    r1_bits,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [31:0]   r1_rdata,
    output logic          dm_cs,
    output logic          dm_r,
    output logic          dm_w,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [1:0]    dm_bits,
    input  logic [31:0]   dm_rdata
);

    state_t      r_state;
    state_t      w_next;
    logic        r_win;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_bits;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        w_valid;
    logic        w_win;
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_cs;
    logic        w_resp;

`ifdef DMEM_ARB_RR_EN
    logic        r_ptr;

    dmem_arb_pick u_pick (
        .i_req0  (r0_req),
        .i_req1  (r1_req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_win   (w_win)
    );
`else
    dmem_arb_pick u_pick (
        .i_req0  (r0_req),
        .i_req1  (r1_req),
        .o_valid (w_valid),
        .o_win   (w_win)
    );
`endif

    // Offset wraps modulo 2^32, so addresses below the base land far out of range
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (w_off >> AW) == 32'd0;
    assign w_cs       = (r_state == ST_ACCESS) && w_in_range;
    assign w_resp     = (r_state == ST_RESP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_bits  <= 2'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
`ifdef DMEM_ARB_RR_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_valid) begin
                r_win   <= w_win;
                r_we    <= w_win ? r1_we    : r0_we;
                r_addr  <= w_win ? r1_addr  : r0_addr;
                r_wdata <= w_win ? r1_wdata : r0_wdata;
                r_bits  <= w_win ? r1_bits  : r0_bits;
`ifdef DMEM_ARB_RR_EN
                r_ptr   <= ~w_win;
`endif
            end
            if (r_state == ST_ACCESS) begin
                r_err   <= ~w_in_range;
                r_rdata <= (w_in_range && !r_we) ? dm_rdata : 32'd0;
            end
        end
    end

    assign dm_cs    = w_cs;
    assign dm_r     = w_cs & ~r_we;
    assign dm_w     = w_cs & r_we;
    assign dm_addr  = w_cs ? w_off[AW-1:0] : '0;
    assign dm_wdata = w_cs ? r_wdata : 32'd0;
    assign dm_bits  = w_cs ? r_bits : 2'd0;

    assign r0_ack   = w_resp & ~r_win;
    assign r1_ack   = w_resp & r_win;
    assign r0_err   = r0_ack & r_err;
    assign r1_err   = r1_ack & r_err;
    assign r0_rdata = r0_ack ? r_rdata : 32'd0;
    assign r1_rdata = r1_ack ? r_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - Self-checking bench for dmem_arbiter (transaction model; honours DMEM_ARB_RR_EN).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int          AW    = 11;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1 << AW;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [31:0]   r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic [1:0]    r0_bits = 0, r1_bits = 0;
    logic          r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0]   r0_rdata, r1_rdata;
    logic          dm_cs, dm_r, dm_w;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [1:0]    dm_bits;
    logic [31:0]   dm_rdata;

    logic [31:0]   dmem    [DEPTH];
    logic [31:0]   ref_mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .clk_in(clk_in), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_bits(r0_bits),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_bits(r1_bits),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_bits(dm_bits), .dm_rdata(dm_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Word-wide DMEM stand-in: combinational read, write on the strobe
    assign dm_rdata = dmem[dm_addr];
    always @(posedge clk_in) if (dm_w) dmem[dm_addr] <= dm_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 memory access, 2 response
    int          m_phase = 0;
    logic        m_ptr = 0;
    logic        m_win = 0, m_we = 0, m_inr = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_off = 0, m_rd = 0;
    logic [1:0]  m_bits = 0;

    always @(negedge reset) begin
        m_phase = 0;
        m_ptr   = 0;
    end

    always @(posedge clk_in) begin
        if (!reset) begin
            m_phase = 0;
            m_ptr   = 0;
        end else begin
            case (m_phase)
                0: if (r0_req || r1_req) begin
`ifdef DMEM_ARB_RR_EN
                    m_win = (r0_req && r1_req) ? m_ptr : r1_req;
                    m_ptr = !m_win;
`else
                    m_win = !r0_req;
`endif
                    m_we    = m_win ? r1_we    : r0_we;
                    m_addr  = m_win ? r1_addr  : r0_addr;
                    m_wdata = m_win ? r1_wdata : r0_wdata;
                    m_bits  = m_win ? r1_bits  : r0_bits;
                    m_off   = m_addr - BASE;
                    m_inr   = m_off < DEPTH;
                    m_phase = 1;
                end
                1: begin
                    m_rd = (m_inr && !m_we) ? ref_mem[m_off[AW-1:0]] : 32'd0;
                    if (m_inr && m_we) ref_mem[m_off[AW-1:0]] = m_wdata;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk_in) begin
        logic acc, a0, a1;
        acc = (m_phase == 1) && m_inr;
        a0  = (m_phase == 2) && !m_win;
        a1  = (m_phase == 2) && m_win;
        chk("dm_cs", dm_cs, acc);
        chk("dm_r", dm_r, acc && !m_we);
        chk("dm_w", dm_w, acc && m_we);
        chk("dm_addr", dm_addr, acc ? m_off[AW-1:0] : 0);
        chk("dm_wdata", dm_wdata, acc ? m_wdata : 0);
        chk("dm_bits", dm_bits, acc ? m_bits : 0);
        chk("r0_ack", r0_ack, a0);
        chk("r1_ack", r1_ack, a1);
        chk("r0_err", r0_err, a0 && !m_inr);
        chk("r1_err", r1_err, a1 && !m_inr);
        chk("r0_rdata", r0_rdata, a0 ? m_rd : 0);
        chk("r1_rdata", r1_rdata, a1 ? m_rd : 0);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req0(input logic we, input logic [31:0] a, input logic [31:0] d);
        r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; r0_bits = BITS_WORD;
    endtask

    task automatic req1(input logic we, input logic [31:0] a, input logic [31:0] d);
        r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; r1_bits = BITS_WORD;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dmem[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        #12;
        chk("reset_outputs", {dm_cs, dm_r, dm_w, r0_ack, r1_ack, r0_err, r1_err}, 0);
        tick();
        reset = 1;
        tick();

        // word write then read back through requester 0
        req0(1, 32'h1001_0004, 32'hDEAD_BEEF);
        tick();
        chk("wr_dm_w", dm_w, 1);
        chk("wr_dm_addr", dm_addr, 4);
        chk("wr_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_ack", r0_ack, 1);
        chk("wr_dm_w_pulse", dm_w, 0);
        r0_req = 0;
        tick();
        req0(0, 32'h1001_0004, 32'h0);
        tick();
        chk("rd_dm_r", dm_r, 1);
        chk("rd_ack_early", r0_ack, 0);
        tick();
        chk("rd_ack", r0_ack, 1);
        chk("rd_data", r0_rdata, 32'hDEAD_BEEF);
        chk("rd_err", r0_err, 0);
        r0_req = 0;
        tick();

        // just past the top of DMEM
        req1(0, 32'h1001_0800, 32'h0);
        tick();
        chk("oor_cs", dm_cs, 0);
        tick();
        chk("oor_ack", r1_ack, 1);
        chk("oor_err", r1_err, 1);
        chk("oor_rdata", r1_rdata, 0);
        r1_req = 0;
        tick();

        // below base, wraps to a huge offset
        req0(0, 32'h0FFF_FFFC, 32'h0);
        tick();
        chk("below_cs", {dm_cs, dm_r, dm_w}, 0);
        tick();
        chk("below_err", r0_err, 1);
        r0_req = 0;
        tick();

        // r1 drops right after the latch; r0 queued behind it
        req1(0, 32'h1001_0004, 32'h0);
        tick();
        r1_req = 0;
        req0(0, 32'h1001_0008, 32'h0);
        tick();
        chk("drop_r1_ack", r1_ack, 1);
        chk("drop_r1_data", r1_rdata, 32'hDEAD_BEEF);
        tick();
        tick();
        tick();
        chk("drop_r0_next", r0_ack, 1);
        r0_req = 0;
        tick();

        // reset hits mid-ACCESS of a write
        req0(1, 32'h1001_0010, 32'h1234_5678);
        tick();
        chk("rst_dm_w_before", dm_w, 1);
        #2 reset = 0;
        #1;
        chk("rst_dm_w_async", dm_w, 0);
        chk("rst_outputs", {dm_cs, dm_r, dm_addr, dm_wdata, r0_ack, r1_ack, r0_rdata}, 0);
        r0_req = 0;
        tick();
        tick();
        reset = 1;
        tick();
        chk("rst_no_ack", {r0_ack, r1_ack}, 0);
        tick();
        chk("rst_no_ack2", {r0_ack, r1_ack}, 0);

        // both held high across four transactions
        req0(0, 32'h1001_0004, 32'h0);
        req1(0, 32'h1001_0008, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
`ifdef DMEM_ARB_RR_EN
            chk($sformatf("grant_%0d", k), {r1_ack, r0_ack}, (k % 2) ? 2'b10 : 2'b01);
`else
            chk($sformatf("grant_%0d", k), {r1_ack, r0_ack}, 2'b01);
`endif
            tick();
        end
        r0_req = 0;
        r1_req = 0;
        tick();

        // randomized traffic, payloads may change at any time
        for (int c = 0; c < 3000; c++) begin
            r0_req   = ($urandom_range(0, 99) < 45);
            r1_req   = ($urandom_range(0, 99) < 45);
            r0_we    = $urandom_range(0, 1);
            r1_we    = $urandom_range(0, 1);
            r0_wdata = $urandom;
            r1_wdata = $urandom;
            r0_bits  = 2'($urandom_range(0, 2));
            r1_bits  = 2'($urandom_range(0, 2));
            r0_addr  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, 15));
            r1_addr  = ($urandom_range(0, 9) == 0) ? BASE + 32'h800 - 32'(4 * $urandom_range(-1, 1))
                                                   : BASE + 32'(4 * $urandom_range(0, 15));
            tick();
        end
        r0_req = 0;
        r1_req = 0;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h10010000, the byte address mapped to DMEM word 0.
REQ-002 The module SHALL have parameter AW, default 11, the DMEM address width.
REQ-003 The module SHALL have these ports:
- clk_in  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 (CPU) access request.
- r0_we  in  1  requester 0 write/read select.
- r0_addr  in  32  requester 0 byte address.
- r0_wdata  in  32  requester 0 write data.
- r0_bits  in  2  requester 0 width code (DMEM Bit_S encoding).
- r0_ack  out  1  requester 0 access complete.
- r0_err  out  1  requester 0 address out of range.
- r0_rdata  out  32  requester 0 read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_bits, r1_ack, r1_err, r1_rdata  same as r0_*, for requester 1 (debug/DMA).
- dm_cs  out  1  DMEM chip select.
- dm_r  out  1  DMEM read strobe.
- dm_w  out  1  DMEM write strobe.
- dm_addr  out  AW  DMEM offset.
- dm_wdata  out  32  DMEM write data.
- dm_bits  out  2  DMEM width code.
- dm_rdata  in  32  DMEM combinational read data.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-005 In IDLE with any rN_req high, the arbiter SHALL latch the winner's we/addr/wdata/bits and go to ACCESS on the next edge.
REQ-006 The offset SHALL be addr - BASE_ADDR, computed 32-bit modulo; it is in range only if bits [31:AW] are zero.
REQ-007 In ACCESS with the offset in range, dm_cs SHALL be 1, dm_r SHALL equal !we, dm_w SHALL equal we, dm_addr SHALL equal offset[AW-1:0], and dm_wdata and dm_bits SHALL carry the latched values; dm_rdata SHALL be registered at the end of ACCESS.
REQ-008 In ACCESS with the offset out of range, all dm_* strobes SHALL stay 0 and the error flag SHALL be latched.
REQ-009 In RESP the arbiter SHALL drive the winner's ack high for exactly one cycle, with rdata (reads only, else 0) and err valid in that same cycle, then return to IDLE.
REQ-010 Latency SHALL be fixed: request sampled at edge N, ack high in cycle N+2; minimum request-to-request spacing is 3 cycles.
REQ-011 A requester SHALL hold req and payload stable until its ack; the arbiter SHALL ignore payload changes after the latch.
REQ-012 A request dropped before ack SHALL still complete; its ack SHALL be issued and may be ignored.
REQ-013 When both requests are high in IDLE, arbitration SHALL follow REQ-017.
REQ-014 Outside ACCESS, dm_cs, dm_r and dm_w SHALL be 0; outside RESP, both acks SHALL be 0.

Reset
REQ-015 While reset is low, the state SHALL be IDLE and every output and internal register SHALL be 0, with priority pointer = requester 0.
REQ-016 Reset asserted mid-ACCESS SHALL drop the dm_w strobe asynchronously; the in-flight transaction SHALL be lost without any ack.

Configuration
REQ-017 Arbitration mode SHALL be selected by macro DMEM_ARB_RR_EN:
- Defined: round-robin; a 1-bit pointer names the preferred requester on a tie, and it flips to the non-winner on each grant.
- Undefined: fixed priority; requester 0 always wins a tie, and the pointer logic is absent.

Structure
REQ-018 A shared package dmem_arb_pkg SHALL hold the state enum, the Bit_S width-code constants (word/half/byte) and the BASE_ADDR default.
REQ-019 One sub-module, dmem_arb_pick, SHALL implement the combinational two-way grant selection (fixed/RR).

Verification
REQ-020 The bench SHALL cover these scenarios:
- r0 write 0xDEADBEEF to 0x10010004 (word), then r0 read 0x10010004 -> dm_addr=4, dm_w pulse 1 cycle; read ack at N+2 with r0_rdata=0xDEADBEEF, r0_err=0.
- r1 read 0x10010800 (AW=11) -> no dm_cs, r1_ack at N+2 with r1_err=1, r1_rdata=0.
- r0 and r1 both held high for 4 transactions, RR defined -> grant order 0,1,0,1; undefined -> 0,0,0,0 while r0 stays high.
- reset pulsed low during ACCESS of a write -> dm_w falls immediately, no ack, state IDLE, all outputs 0.
- r1 drops req the cycle after latch -> r1_ack still pulses at N+2, and a pending r0 is served next.
- Address 0x0FFFFFFC (below base, wraps) -> r0_err=1, no memory strobe.
